// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one single-ported synchronous RAM (registered q, READ_LAT
//           cycles of read latency) between the fetch unit (read-only) and the
//           memory stage (loads/stores). Every access runs
//           IDLE -> ACCESS -> WAIT (READ_LAT cycles) -> RESP -> IDLE.
//           Data requests have priority over fetch. Fetch is forced through
//           after MAX_STARVE data grants that it has had to wait behind.
// Ports   : clk, rst_n (async, active low)
//           f_req/f_addr            -> f_done/f_rdata   fetch requester
//           d_req/d_wr/d_addr/d_wdata -> d_done/d_rdata data requester
//           ram_addr/ram_wren/ram_data -> RAM, ram_q <- RAM
//           busy  : FSM not idle
//           owner : 0 = fetch, 1 = data (current / last access)
// Option  : MEM_ARB_STATS_EN adds stat_f_grants, stat_d_grants and
//           stat_conflicts (16-bit saturating counters).
// Revision: 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 1,
    parameter int MAX_STARVE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
`ifdef MEM_ARB_STATS_EN
    output logic [15:0]       stat_f_grants,
    output logic [15:0]       stat_d_grants,
    output logic [15:0]       stat_conflicts,
`endif
    output logic              owner
);

    localparam logic [1:0] c_s_idle   = 2'd0;
    localparam logic [1:0] c_s_access = 2'd1;
    localparam logic [1:0] c_s_wait   = 2'd2;
    localparam logic [1:0] c_s_resp   = 2'd3;

    // Sized with headroom so MAX_STARVE itself is always representable.
    localparam int                  c_starve_w   = $clog2(MAX_STARVE + 2);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(MAX_STARVE);
    localparam logic [2:0]          c_wait_init  = 3'(READ_LAT - 1);

    logic [1:0]            r_state;
    logic [2:0]            r_wait_cnt;
    logic [c_starve_w-1:0] r_starve;
    logic                  r_wr;

    logic w_grant;
    logic w_pick_f;

    assign w_grant  = (r_state == c_s_idle) && (f_req || d_req);
    // Fetch wins when it is alone or when it has been starved long enough.
    assign w_pick_f = f_req && (!d_req || (r_starve == c_starve_max));

    assign f_done = (r_state == c_s_resp) && !owner;
    assign d_done = (r_state == c_s_resp) &&  owner;
    assign busy   = (r_state != c_s_idle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_s_idle;
            r_wait_cnt <= '0;
            r_starve   <= '0;
            r_wr       <= 1'b0;
            owner      <= 1'b0;
            ram_addr   <= '0;
            ram_wren   <= 1'b0;
            ram_data   <= '0;
            f_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (w_grant) begin
                        r_state  <= c_s_access;
                        owner    <= !w_pick_f;
                        r_wr     <= !w_pick_f && d_wr;
                        // Address and write strobe are registered here so the
                        // RAM sees them for the whole ACCESS cycle.
                        ram_wren <= !w_pick_f && d_wr;
                        if (w_pick_f) begin
                            ram_addr <= f_addr;
                            r_starve <= '0;
                        end else begin
                            ram_addr <= d_addr;
                            ram_data <= d_wdata;
                            if (f_req && (r_starve != c_starve_max))
                                r_starve <= r_starve + 1'b1;
                        end
                    end
                end
                c_s_access: begin
                    ram_wren   <= 1'b0;
                    r_wait_cnt <= c_wait_init;
                    r_state    <= c_s_wait;
                end
                c_s_wait: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_state <= c_s_resp;
                        // ram_q reflects the ACCESS-cycle address only now.
                        if (!r_wr) begin
                            if (owner)
                                d_rdata <= ram_q;
                            else
                                f_rdata <= ram_q;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_s_idle;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_f_grants  <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else if (w_grant) begin
            if (w_pick_f && (stat_f_grants != 16'hFFFF))
                stat_f_grants <= stat_f_grants + 16'd1;
            if (!w_pick_f && (stat_d_grants != 16'hFFFF))
                stat_d_grants <= stat_d_grants + 16'd1;
            if (f_req && d_req && (stat_conflicts != 16'hFFFF))
                stat_conflicts <= stat_conflicts + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Scoreboard bench for mem_port_arbiter. Two instances: READ_LAT=1
//           and READ_LAT=3, each with its own RAM model. Stimulus pushes the
//           expected completions; one monitor process performs every compare.
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct {
        bit          own;
        logic [31:0] data;
        bit          chk;
        int          cyc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n;

    // instance A (READ_LAT = 1)
    logic          f_req, f_done, d_req, d_wr, d_done, ram_wren, busy, owner;
    logic [AW-1:0] f_addr, d_addr, ram_addr;
    logic [DW-1:0] f_rdata, d_wdata, d_rdata, ram_data, ram_q;
    // instance B (READ_LAT = 3)
    logic          f_req3, f_done3, d_req3, d_wr3, d_done3, ram_wren3, busy3, owner3;
    logic [AW-1:0] f_addr3, d_addr3, ram_addr3;
    logic [DW-1:0] f_rdata3, d_wdata3, d_rdata3, ram_data3, ram_q3;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] st_f, st_d, st_c, st_f3, st_d3, st_c3;
`endif

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .MAX_STARVE(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q),
        .busy(busy),
`ifdef MEM_ARB_STATS_EN
        .stat_f_grants(st_f), .stat_d_grants(st_d), .stat_conflicts(st_c),
`endif
        .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .MAX_STARVE(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req3), .f_addr(f_addr3), .f_done(f_done3), .f_rdata(f_rdata3),
        .d_req(d_req3), .d_wr(d_wr3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_done(d_done3), .d_rdata(d_rdata3),
        .ram_addr(ram_addr3), .ram_wren(ram_wren3), .ram_data(ram_data3), .ram_q(ram_q3),
        .busy(busy3),
`ifdef MEM_ARB_STATS_EN
        .stat_f_grants(st_f3), .stat_d_grants(st_d3), .stat_conflicts(st_c3),
`endif
        .owner(owner3)
    );

    // RAM models: registered output, preload port shared by both.
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] mem  [256];
    logic [DW-1:0] mem3 [256];
    logic [DW-1:0] qa, q3a, q3b, q3c;

    always @(posedge clk) begin
        if (pl_en)         mem[pl_addr]  <= pl_data;
        else if (ram_wren) mem[ram_addr] <= ram_data;
        qa <= mem[ram_addr];
    end
    assign ram_q = qa;

    always @(posedge clk) begin
        if (pl_en)          mem3[pl_addr]   <= pl_data;
        else if (ram_wren3) mem3[ram_addr3] <= ram_data3;
        q3a <= mem3[ram_addr3];
        q3b <= q3a;
        q3c <= q3b;
    end
    assign ram_q3 = q3c;

    // ---------------------------------------------------------------- checker
    exp_t sbq[$];
    exp_t sbq3[$];
    chk_t chkq[$];
    int   tests   = 0;
    int   failed  = 0;
    int   wren_cnt = 0;
    exp_t e;
    chk_t c;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        while (chkq.size() > 0) begin
            c = chkq.pop_front();
            cmp(c.name, c.act, c.exp);
        end
        if (ram_wren) wren_cnt = wren_cnt + 1;
        if (f_done || d_done) begin
            cmp("A_one_done", {31'd0, f_done & d_done}, 32'd0);
            if (sbq.size() == 0) begin
                cmp("A_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                cmp("A_done_owner", {31'd0, d_done}, {31'd0, e.own});
                cmp("A_owner_out",  {31'd0, owner},  {31'd0, e.own});
                cmp("A_done_cycle", cyc, e.cyc);
                if (e.chk) cmp("A_rdata", e.own ? d_rdata : f_rdata, e.data);
            end
        end
        if (f_done3 || d_done3) begin
            cmp("B_one_done", {31'd0, f_done3 & d_done3}, 32'd0);
            if (sbq3.size() == 0) begin
                cmp("B_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq3.pop_front();
                cmp("B_done_owner", {31'd0, d_done3}, {31'd0, e.own});
                cmp("B_done_cycle", cyc, e.cyc);
                if (e.chk) cmp("B_rdata", e.own ? d_rdata3 : f_rdata3, e.data);
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    task automatic drop_reqs();
        f_req = 0; d_req = 0; f_req3 = 0; d_req3 = 0;
    endtask

    // One complete access; b selects the READ_LAT=3 instance.
    task automatic access(input bit b, input bit own, input bit wr,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] ed, input bit chk);
        bit seen;
        seen = 0;
        if (!b) begin
            if (own) begin d_req = 1; d_wr = wr; d_addr = addr; d_wdata = wd; end
            else     begin f_req = 1; f_addr = addr; end
            sbq.push_back('{own, ed, chk, cyc + 3});
        end else begin
            if (own) begin d_req3 = 1; d_wr3 = wr; d_addr3 = addr; d_wdata3 = wd; end
            else     begin f_req3 = 1; f_addr3 = addr; end
            sbq3.push_back('{own, ed, chk, cyc + 5});
        end
        @(posedge clk); #1;
        // Post-grant changes must not affect the access in flight.
        f_addr  = ~f_addr;  d_addr  = ~d_addr;  d_wdata  = ~d_wdata;
        f_addr3 = ~f_addr3; d_addr3 = ~d_addr3; d_wdata3 = ~d_wdata3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b ? (f_done3 || d_done3) : (f_done || d_done)) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chkq.push_back('{"done_timeout", 32'd0, 32'd1});
        @(posedge clk); #1;
        drop_reqs();
    endtask

    int w0;
    int n0;
    int ndone;

    initial begin
        rst_n = 0; pl_en = 0; pl_addr = '0; pl_data = '0;
        f_req = 0; f_addr = '0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        f_req3 = 0; f_addr3 = '0; d_req3 = 0; d_wr3 = 0; d_addr3 = '0; d_wdata3 = '0;
        @(posedge clk); #1;
        preload(8'h05, 32'hE3A0_0001);
        preload(8'h0A, 32'd11);
        preload(8'h1D, 32'h5555_AAAA);
        preload(8'h30, 32'h1234_5678);
        preload(8'h40, 32'hCAFE_BABE);

        // reset state
        @(negedge clk);
        chkq.push_back('{"rst_busy",     {31'd0, busy},     32'd0});
        chkq.push_back('{"rst_owner",    {31'd0, owner},    32'd0});
        chkq.push_back('{"rst_dones",    {30'd0, f_done, d_done}, 32'd0});
        chkq.push_back('{"rst_wren",     {31'd0, ram_wren}, 32'd0});
        chkq.push_back('{"rst_ram_addr", {24'd0, ram_addr}, 32'd0});
        chkq.push_back('{"rst_ram_data", ram_data,          32'd0});
        chkq.push_back('{"rst_f_rdata",  f_rdata,           32'd0});
        chkq.push_back('{"rst_d_rdata",  d_rdata,           32'd0});
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // 1: fetch only
        w0 = wren_cnt;
        access(0, 0, 0, 8'h05, 32'd0, 32'hE3A0_0001, 1);
        chkq.push_back('{"t1_no_wren", wren_cnt - w0, 32'd0});

        // 2: store then load
        w0 = wren_cnt;
        access(0, 1, 1, 8'h1D, 32'd8, 32'd0, 0);
        chkq.push_back('{"t2_wren_once", wren_cnt - w0, 32'd1});
        chkq.push_back('{"t2_mem",       mem[8'h1D],    32'd8});
        access(0, 1, 0, 8'h1D, 32'd0, 32'd8, 1);
        chkq.push_back('{"t2_f_rdata_held", f_rdata, 32'hE3A0_0001});

        // 4: READ_LAT = 3 load
        access(1, 1, 0, 8'h0A, 32'd0, 32'd11, 1);

        // 5: reset in the middle of a load's WAIT
        d_req = 1; d_wr = 0; d_addr = 8'h30;
        @(posedge clk);          // grant -> ACCESS
        @(posedge clk); #1;      // now in WAIT
        rst_n = 0;
        drop_reqs();
        #1;
        chkq.push_back('{"t5_busy_async", {31'd0, busy}, 32'd0});
        @(posedge clk); #1;
        rst_n = 1;
        w0 = wren_cnt;
        repeat (6) @(negedge clk);
        chkq.push_back('{"t5_no_wren",  wren_cnt - w0, 32'd0});
        chkq.push_back('{"t5_mem_keep", mem[8'h30],    32'h1234_5678});
        chkq.push_back('{"t5_d_rdata",  d_rdata,       32'd0});
        @(posedge clk); #1;
        access(0, 0, 0, 8'h40, 32'd0, 32'hCAFE_BABE, 1);

        // 3: contention from a fresh reset
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        f_req = 1; f_addr = 8'h05; d_req = 1; d_wr = 0; d_addr = 8'h1D;
        n0 = cyc;
        for (int k = 0; k < 8; k++) begin
            if ((k % 4) == 3) sbq.push_back('{1'b0, 32'hE3A0_0001, 1'b1, n0 + 3 + 4 * k});
            else              sbq.push_back('{1'b1, 32'd8,         1'b1, n0 + 3 + 4 * k});
        end
        ndone = 0;
        for (int i = 0; i < 60 && ndone < 8; i++) begin
            @(negedge clk);
            if (f_done || d_done) ndone++;
        end
        chkq.push_back('{"t3_done_count", ndone, 32'd8});
        @(posedge clk); #1;
        drop_reqs();
        @(negedge clk);
        chkq.push_back('{"t3_idle_after", {31'd0, busy}, 32'd0});
`ifdef MEM_ARB_STATS_EN
        chkq.push_back('{"t6_stat_d", {16'd0, st_d}, 32'd6});
        chkq.push_back('{"t6_stat_f", {16'd0, st_f}, 32'd2});
        chkq.push_back('{"t6_stat_c", {16'd0, st_c}, 32'd8});
`endif
        repeat (3) @(negedge clk);
        chkq.push_back('{"sb_drained", sbq.size() + sbq3.size(), 32'd0});
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
